// File: rtl/fma_stage2_csa_tree.sv
// rtl/fma_stage2_csa_tree.sv - FMA stage 2: Booth rows plus aligned addend reduced to a carry-save pair
// Stage 2a reduces 15 rows to 4, stage 2b reduces 4 to 2; valid/ready handshake on both sides.
`timescale 1ns/1ps
module fma_stage2_csa_tree (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [35:0] partial_mul,
  input  logic        man_b_msb,
  input  logic [23:0] man_a,
  input  logic [23:0] man_c,
  input  logic [7:0]  shift,
  input  logic        right_or_left,
  input  logic [7:0]  current_exp,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic        sign_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [75:0] out_sum,
  output logic [75:0] out_carry,
  output logic [7:0]  out_exp,
  output logic        out_sign_p,
  output logic        out_eff_sub,
  output logic        out_sticky,
  output logic        out_c_dom
);
  localparam int FIELD_W    = 76;
  localparam int PROD_OFS   = 26;
  localparam int ALIGN_BASE = 49;
  localparam int NROWS      = 15;

  function automatic logic [FIELD_W-1:0] csa_s(input logic [FIELD_W-1:0] x, input logic [FIELD_W-1:0] y,
                                               input logic [FIELD_W-1:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [FIELD_W-1:0] csa_c(input logic [FIELD_W-1:0] x, input logic [FIELD_W-1:0] y,
                                               input logic [FIELD_W-1:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic                      v2a_q, v2a_d, v2b_q, v2b_d;
  logic                      s2b_ready, ld_2a, ld_2b;
  logic [3:0][FIELD_W-1:0]   r4_q, r4_d;
  logic [7:0]                exp2a_q, exp2a_d, exp2b_q, exp2b_d;
  logic                      sp2a_q, sp2a_d, es2a_q, es2a_d, st2a_q, st2a_d, cd2a_q, cd2a_d;
  logic                      sp2b_q, sp2b_d, es2b_q, es2b_d, st2b_q, st2b_d, cd2b_q, cd2b_d;
  logic [FIELD_W-1:0]        sum_q, sum_d, carry_q, carry_d;

  logic [FIELD_W-1:0]        rows [NROWS];
  logic [FIELD_W-1:0]        addend;
  logic                      sticky, c_dom, eff_sub;

  always_comb begin
    s2b_ready = !v2b_q || out_ready;
    in_ready  = !v2a_q || s2b_ready;
    ld_2a     = in_valid && in_ready;
    ld_2b     = v2a_q && s2b_ready;
    v2a_d     = in_ready ? in_valid : v2a_q;
    v2b_d     = s2b_ready ? v2a_q : v2b_q;
  end

  always_comb begin : row_gen
    logic [38:0]          digs;
    logic [2:0]           dig;
    logic [FIELD_W-1:0]   mag;
    logic [FIELD_W-1:0]   corr;
    logic [FIELD_W-1:0]   base;
    logic [2*FIELD_W-1:0] wide;
    digs    = {2'b00, man_b_msb, partial_mul};
    dig     = '0;
    mag     = '0;
    corr    = '0;
    wide    = '0;
    addend  = '0;
    sticky  = 1'b0;
    c_dom   = 1'b0;
    eff_sub = sign_a ^ sign_b ^ sign_c;
    base    = FIELD_W'(man_c) << ALIGN_BASE;
    // Negative rows are ~(|d|*A) shifted; the two's-complement +1 lands on the row's own LSB in corr.
    for (int i = 0; i < 13; i++) begin
      dig = 3'(digs >> (3 * i));
      case (dig)
        3'b001, 3'b111: mag = FIELD_W'(man_a);
        3'b010, 3'b110: mag = FIELD_W'(man_a) << 1;
        default:        mag = '0;
      endcase
      if (dig == 3'b110 || dig == 3'b111) begin
        rows[i] = ~mag << (PROD_OFS + 2 * i);
        corr    = corr | (FIELD_W'(1) << (PROD_OFS + 2 * i));
      end else begin
        rows[i] = mag << (PROD_OFS + 2 * i);
      end
    end
    if (!right_or_left) begin
      if (shift > 8'd2) begin
        addend = base << 2;
        c_dom  = 1'b1;
      end else begin
        addend = base << shift;
      end
    end else if (shift >= 8'd73) begin
      sticky = |man_c;
    end else begin
      wide   = {base, {FIELD_W{1'b0}}} >> shift;
      addend = wide[2*FIELD_W-1:FIELD_W];
      sticky = |wide[FIELD_W-1:0];
    end
    rows[13] = eff_sub ? ~addend : addend;
    rows[14] = corr | FIELD_W'(eff_sub);
  end

  always_comb begin : tree_2a
    logic [FIELD_W-1:0] sa, ca, sb, cb, t;
    sa = rows[0];
    ca = rows[1];
    for (int j = 2; j < 8; j++) begin
      t  = csa_s(sa, ca, rows[j]);
      ca = csa_c(sa, ca, rows[j]);
      sa = t;
    end
    sb = rows[8];
    cb = rows[9];
    for (int j = 10; j < NROWS; j++) begin
      t  = csa_s(sb, cb, rows[j]);
      cb = csa_c(sb, cb, rows[j]);
      sb = t;
    end
    r4_d    = r4_q;
    exp2a_d = exp2a_q;
    sp2a_d  = sp2a_q;
    es2a_d  = es2a_q;
    st2a_d  = st2a_q;
    cd2a_d  = cd2a_q;
    if (ld_2a) begin
      r4_d    = {cb, sb, ca, sa};
      exp2a_d = current_exp;
      sp2a_d  = sign_a ^ sign_b;
      es2a_d  = eff_sub;
      st2a_d  = sticky;
      cd2a_d  = c_dom;
    end
  end

  always_comb begin : tree_2b
    logic [FIELD_W-1:0] s1, c1;
    s1      = csa_s(r4_q[0], r4_q[1], r4_q[2]);
    c1      = csa_c(r4_q[0], r4_q[1], r4_q[2]);
    sum_d   = sum_q;
    carry_d = carry_q;
    exp2b_d = exp2b_q;
    sp2b_d  = sp2b_q;
    es2b_d  = es2b_q;
    st2b_d  = st2b_q;
    cd2b_d  = cd2b_q;
    if (ld_2b) begin
      sum_d   = csa_s(s1, c1, r4_q[3]);
      carry_d = csa_c(s1, c1, r4_q[3]);
      exp2b_d = exp2a_q;
      sp2b_d  = sp2a_q;
      es2b_d  = es2a_q;
      st2b_d  = st2a_q;
      cd2b_d  = cd2a_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2a_q   <= 1'b0;
      v2b_q   <= 1'b0;
      r4_q    <= '0;
      exp2a_q <= '0;
      sp2a_q  <= 1'b0;
      es2a_q  <= 1'b0;
      st2a_q  <= 1'b0;
      cd2a_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
      exp2b_q <= '0;
      sp2b_q  <= 1'b0;
      es2b_q  <= 1'b0;
      st2b_q  <= 1'b0;
      cd2b_q  <= 1'b0;
    end else begin
      v2a_q   <= v2a_d;
      v2b_q   <= v2b_d;
      r4_q    <= r4_d;
      exp2a_q <= exp2a_d;
      sp2a_q  <= sp2a_d;
      es2a_q  <= es2a_d;
      st2a_q  <= st2a_d;
      cd2a_q  <= cd2a_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      exp2b_q <= exp2b_d;
      sp2b_q  <= sp2b_d;
      es2b_q  <= es2b_d;
      st2b_q  <= st2b_d;
      cd2b_q  <= cd2b_d;
    end
  end

  assign out_valid   = v2b_q;
  assign out_sum     = sum_q;
  assign out_carry   = carry_q;
  assign out_exp     = exp2b_q;
  assign out_sign_p  = sp2b_q;
  assign out_eff_sub = es2b_q;
  assign out_sticky  = st2b_q;
  assign out_c_dom   = cd2b_q;
endmodule

// File: tb/tb_fma_stage2_csa_tree.sv
// tb/tb_fma_stage2_csa_tree.sv - table-driven and scoreboard bench for fma_stage2_csa_tree
`timescale 1ns/1ps
module tb_fma_stage2_csa_tree;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [35:0] partial_mul = '0;
  logic        man_b_msb = 1'b0;
  logic [23:0] man_a = '0;
  logic [23:0] man_c = '0;
  logic [7:0]  shift = '0;
  logic        right_or_left = 1'b0;
  logic [7:0]  current_exp = '0;
  logic        sign_a = 1'b0, sign_b = 1'b0, sign_c = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [75:0] out_sum, out_carry;
  logic [7:0]  out_exp;
  logic        out_sign_p, out_eff_sub, out_sticky, out_c_dom;

  always #5 clk = ~clk;

  fma_stage2_csa_tree dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .partial_mul(partial_mul), .man_b_msb(man_b_msb), .man_a(man_a), .man_c(man_c),
    .shift(shift), .right_or_left(right_or_left), .current_exp(current_exp),
    .sign_a(sign_a), .sign_b(sign_b), .sign_c(sign_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
    .out_exp(out_exp), .out_sign_p(out_sign_p), .out_eff_sub(out_eff_sub),
    .out_sticky(out_sticky), .out_c_dom(out_c_dom)
  );

  typedef struct {
    logic [35:0] pm;
    logic        msb;
    logic [23:0] a;
    logic [23:0] c;
    logic [7:0]  sh;
    logic        rol;
    logic [7:0]  ex;
    logic        sa, sb, sc;
  } stim_t;

  typedef struct {
    logic [75:0] val;
    logic [7:0]  ex;
    logic        sp, es, st, cd;
  } res_t;

  typedef struct {
    stim_t s;
    res_t  e;
  } vec_t;

  res_t        sb_q[$];
  res_t        pending;
  vec_t        tv[14];
  int          n_cmp = 0, n_fail = 0, n_out = 0;
  int          stall_cnt = 0;
  logic        rand_ready = 1'b0;
  logic        accepted = 1'b0, obs_in_ready = 1'b0;
  logic        held_valid = 1'b0;
  logic [75:0] held_sum, held_carry;

  task automatic chkw(input string name, input logic [75:0] act, input logic [75:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b", name, act, req);
    end
  endtask

  function automatic res_t model(input stim_t s);
    res_t        e;
    longint      m, prod;
    logic [127:0] pw, base, a_v;
    logic [2:0]  d;
    m = 0;
    for (int i = 0; i < 12; i++) begin
      d = 3'(s.pm >> (3 * i));
      case (d)
        3'd1: m += longint'(1) << (2 * i);
        3'd2: m += longint'(2) << (2 * i);
        3'd6: m -= longint'(2) << (2 * i);
        3'd7: m -= longint'(1) << (2 * i);
        default: ;
      endcase
    end
    if (s.msb) m += longint'(1) << 24;
    prod = m * longint'(s.a);
    pw   = {{64{prod[63]}}, prod} << 26;
    base = 128'(s.c) << 49;
    e.st = 1'b0;
    e.cd = 1'b0;
    if (!s.rol) begin
      if (s.sh > 8'd2) begin a_v = base << 2; e.cd = 1'b1; end
      else a_v = base << s.sh;
    end else if (s.sh >= 8'd73) begin
      a_v  = '0;
      e.st = |s.c;
    end else begin
      a_v  = base >> s.sh;
      e.st = ((a_v << s.sh) != base);
    end
    e.ex  = s.ex;
    e.sp  = s.sa ^ s.sb;
    e.es  = s.sa ^ s.sb ^ s.sc;
    e.val = e.es ? (pw[75:0] - a_v[75:0]) : (pw[75:0] + a_v[75:0]);
    return e;
  endfunction

  function automatic vec_t mk(input logic [35:0] pm, input logic msb, input logic [23:0] a,
                              input logic [23:0] c, input logic [7:0] sh, input logic rol,
                              input logic sa, input logic sb, input logic sc,
                              input logic [75:0] val, input logic st, input logic cd);
    vec_t v;
    v.s = '{pm: pm, msb: msb, a: a, c: c, sh: sh, rol: rol, ex: 8'h00, sa: sa, sb: sb, sc: sc};
    v.e = '{val: val, ex: 8'h00, sp: sa ^ sb, es: sa ^ sb ^ sc, st: st, cd: cd};
    return v;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t       s;
    logic [63:0] r;
    r     = {$urandom(), $urandom()};
    s.pm  = r[35:0];
    s.msb = r[40];
    s.a   = 24'($urandom()) | 24'h800000;
    s.c   = 24'($urandom()) | 24'h800000;
    case ($urandom_range(0, 2))
      0:       s.sh = 8'($urandom_range(0, 5));
      1:       s.sh = 8'($urandom_range(0, 80));
      default: s.sh = 8'($urandom_range(60, 255));
    endcase
    s.rol = r[41];
    s.ex  = r[49:42];
    s.sa  = r[50];
    s.sb  = r[51];
    s.sc  = r[52];
    return s;
  endfunction

  task automatic compare(input res_t e);
    logic [75:0] sc;
    sc = out_sum + out_carry;
    chkw("sum_plus_carry", sc, e.val);
    chkw("out_exp", 76'(out_exp), 76'(e.ex));
    chk1("out_sign_p", out_sign_p, e.sp);
    chk1("out_eff_sub", out_eff_sub, e.es);
    chk1("out_sticky", out_sticky, e.st);
    chk1("out_c_dom", out_c_dom, e.cd);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    else if (stall_cnt > 0) begin out_ready = 1'b0; stall_cnt--; end
    else out_ready = 1'b1;
    #1;
    obs_in_ready = in_ready;
    accepted     = in_valid && in_ready;
    if (accepted) sb_q.push_back(pending);
    if (held_valid) begin
      chk1("stall_valid_held", out_valid, 1'b1);
      chkw("stall_sum_stable", out_sum, held_sum);
      chkw("stall_carry_stable", out_carry, held_carry);
    end
    held_valid = 1'b0;
    if (out_valid) begin
      if (out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: actual sum=%h required no output", out_sum);
        end else begin
          compare(sb_q.pop_front());
        end
      end else begin
        held_valid = 1'b1;
        held_sum   = out_sum;
        held_carry = out_carry;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input stim_t s, input res_t e);
    in_valid      = 1'b1;
    partial_mul   = s.pm;
    man_b_msb     = s.msb;
    man_a         = s.a;
    man_c         = s.c;
    shift         = s.sh;
    right_or_left = s.rol;
    current_exp   = s.ex;
    sign_a        = s.sa;
    sign_b        = s.sb;
    sign_c        = s.sc;
    pending       = e;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (!accepted && n < 50) begin tick(); n++; end
    if (!accepted) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: actual in_ready stuck low required acceptance");
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input stim_t s, input res_t e);
    drive(s, e);
    tick();
    wait_accept();
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((sb_q.size() > 0 || out_valid) && n < 40) begin tick(); n++; end
    chk1("drain_complete", sb_q.size() == 0, 1'b1);
  endtask

  task automatic latency_check(input vec_t v);
    drive(v.s, v.e);
    tick();
    chk1("lat_accept", accepted, 1'b1);
    in_valid = 1'b0;
    chk1("lat_cycle1_not_valid", out_valid, 1'b0);
    tick();
    chk1("lat_cycle2_valid", out_valid, 1'b1);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1);
  end

  initial begin
    stim_t s;
    int    n0;
    logic [75:0] one;
    one   = 76'd1;
    tv[0]  = mk(36'hC00000000, 1'b1, 24'h800000, 24'h000000, 8'd0,   1'b0, 0, 0, 0, one << 72, 0, 0);
    tv[1]  = mk(36'hC00000000, 1'b1, 24'h800000, 24'h800000, 8'd0,   1'b0, 0, 0, 0, one << 73, 0, 0);
    tv[2]  = mk(36'hC00000000, 1'b1, 24'h800000, 24'h800000, 8'd0,   1'b0, 0, 0, 1, 76'd0,     0, 0);
    tv[3]  = mk(36'hC00000000, 1'b1, 24'h800000, 24'hFFFFFF, 8'd60,  1'b1, 0, 0, 0, (one << 72) + 76'h1FFF, 1, 0);
    tv[4]  = mk(36'hC00000000, 1'b1, 24'h800000, 24'hFFFFFF, 8'd200, 1'b1, 0, 0, 0, one << 72, 1, 0);
    tv[5]  = mk(36'hC00000000, 1'b1, 24'h800000, 24'hFFFFFF, 8'd5,   1'b0, 0, 0, 0, (one << 72) + (76'hFFFFFF << 51), 0, 1);
    tv[6]  = mk(36'h0, 1'b0, 24'h800000, 24'h800000, 8'd2,  1'b0, 0, 0, 0, one << 74, 0, 0);
    tv[7]  = mk(36'h0, 1'b0, 24'h800000, 24'h800000, 8'd3,  1'b0, 0, 0, 0, one << 74, 0, 1);
    tv[8]  = mk(36'h0, 1'b0, 24'h800000, 24'h000001, 8'd73, 1'b1, 0, 0, 0, 76'd0, 1, 0);
    tv[9]  = mk(36'h0, 1'b0, 24'h800000, 24'h800000, 8'd72, 1'b1, 0, 0, 0, 76'd1, 0, 0);
    tv[10] = mk(36'h3, 1'b0, 24'hFFFFFF, 24'h000000, 8'd0,  1'b0, 0, 0, 0, 76'd0, 0, 0);
    tv[11] = mk(36'h7, 1'b0, 24'h000001, 24'h000000, 8'd0,  1'b0, 0, 0, 0, 76'd0 - (one << 26), 0, 0);
    tv[12] = mk(36'hC00000000, 1'b1, 24'h800000, 24'h800000, 8'd0, 1'b0, 1, 0, 0, 76'd0, 0, 0);
    tv[13] = mk(36'h4, 1'b0, 24'hFFFFFF, 24'h000000, 8'd0,  1'b0, 0, 0, 0, 76'd0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      tv[i].s.ex = 8'(8'h40 + i);
      tv[i].e.ex = 8'(8'h40 + i);
    end

    repeat (2) @(negedge clk);
    #1;
    chk1("reset_out_valid", out_valid, 1'b0);
    chkw("reset_out_sum", out_sum, 76'd0);
    chkw("reset_out_carry", out_carry, 76'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);

    latency_check(tv[0]);

    for (int i = 0; i < 14; i++) send(tv[i].s, tv[i].e);
    drain();

    n0 = n_out;
    stall_cnt = 5;
    for (int k = 0; k < 4; k++) begin
      s = rnd_stim();
      drive(s, model(s));
      tick();
      if (k == 2) chk1("bp_in_ready_low", obs_in_ready, 1'b0);
      wait_accept();
    end
    drain();
    chkw("bp_output_count", 76'(n_out - n0), 76'd4);

    stall_cnt = 20;
    for (int k = 0; k < 2; k++) begin
      s = rnd_stim();
      send(s, model(s));
    end
    rst = 1'b0;
    #1;
    chk1("rst_out_valid_async", out_valid, 1'b0);
    chkw("rst_out_sum", out_sum, 76'd0);
    sb_q.delete();
    held_valid = 1'b0;
    stall_cnt  = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("rst_no_stale", out_valid, 1'b0);
    end
    latency_check(tv[3]);

    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      s = rnd_stim();
      send(s, model(s));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_ready = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
